bp_port_scheduler: RTL and testbench
====================================

// Module: bp_port_scheduler
// PURPOSE
//   Shares the single-ported 2-bit branch predictor between N_REQ lookup requesters and a stream of
//   resolved-branch updates. The predictor accepts one operation per cycle (lookup or update), so this
//   block buffers updates in a small FIFO, arbitrates lookups round-robin, and returns each prediction
//   tagged with its requester id. It sits between the fetch/resolve logic and the predictor instance.
// PARAMETERS
//   N_REQ      2   number of lookup requesters (>=2)
//   UPD_DEPTH  4   update FIFO depth (power of 2, >=2)
//   MAX_WAIT   8   cycles the FIFO head may wait behind lookups before an update slot is forced (>=1)
// PORTS
//   clk            in   1          clock, all state on rising edge
//   rst_n          in   1          asynchronous, active-low reset
//   lk_req         in   N_REQ      per-requester lookup request, held until granted
//   lk_gnt         out  N_REQ      one-hot grant, combinational, at most one bit set; accepted on edge
//   rsp_valid      out  1          prediction response valid (one cycle per accepted lookup)
//   rsp_id         out  $clog2(N_REQ) requester index of the response
//   rsp_taken      out  1          predicted direction
//   upd_valid      in   1          resolved-branch update offered
//   upd_taken      in   1          actual outcome of the resolved branch
//   upd_ready      out  1          update accepted on edge when upd_valid & upd_ready
//   pr_request     out  1          to predictor: lookup this cycle (registered)
//   pr_result      out  1          to predictor: update this cycle (registered)
//   pr_taken       out  1          to predictor: update outcome (registered)
//   pr_prediction  in   1          from predictor: prediction, valid the cycle after pr_request edge
// BEHAVIOUR
//   Reset: pr_request=pr_result=pr_taken=0, rsp_valid=0, rsp_id=0, rsp pipeline cleared, FIFO empty,
//   age=0, round-robin pointer=0. Reset mid-operation drops queued updates and suppresses in-flight rsp.
//   Slot selection each cycle (combinational, priority order):
//     1. FIFO full OR age==MAX_WAIT            -> UPDATE (pop head)
//     2. any lk_req                            -> LOOKUP (grant round-robin winner)
//     3. FIFO non-empty                        -> UPDATE
//     4. else                                  -> IDLE
//   Never both pr_request and pr_result high. lk_gnt asserted only in LOOKUP slots.
//   Round-robin: search starts at pointer; after a grant to i, pointer <= (i+1) mod N_REQ.
//   Timing: lookup accepted at edge T -> pr_request high T..T+1 -> predictor samples at T+1 ->
//   rsp_valid high T+1..T+2 with rsp_taken = pr_prediction and rsp_id = id registered at T.
//   Update issued at edge T -> pr_result/pr_taken high T..T+1; a lookup issued at T+1 sees the new counter.
//   FIFO: upd_ready = !full (registered occupancy, no full-pass-through). Push and pop in same cycle:
//   occupancy unchanged; push into empty FIFO is not poppable until the next cycle (no bypass).
//   Ordering: updates leave in arrival order; pointers wrap modulo UPD_DEPTH.
//   age: increments each cycle FIFO non-empty and slot != UPDATE, saturates at MAX_WAIT, clears on pop
//   and when FIFO empty.
//   upd_valid while !upd_ready: no state change; source holds data.
// STRUCTURE
//   Package bp_sched_pkg: slot enum {SLOT_IDLE, SLOT_LOOKUP, SLOT_UPDATE}; default parameter constants.
//   Sub-module bp_upd_fifo: UPD_DEPTH x 1-bit sync FIFO (push/pop/full/empty/head, async active-low reset).
//   Top holds arbiter, age counter, issue registers and response pipeline.
// TESTING (predictor instance attached; its counter powers up at 3)
//   1. Reset, lk_req=01 one request -> lk_gnt=01 one cycle, pr_request 1 cycle, rsp_valid next, id=0, taken=1.
//   2. Two upd_valid taken=0, no lookups -> pr_result on 2 consecutive slots, pr_taken=0; then lookup -> taken=0.
//   3. lk_req=11 held 6 cycles -> grants 01,10,01,10,01,10; rsp_id 0,1,0,1,0,1 two cycles later.
//   4. lk_req=11 held, one update pushed -> 8 LOOKUP slots, then forced UPDATE (age==8), lookups resume.
//   5. Lookups saturating, push 5 updates back-to-back -> upd_ready low after 4th; forced UPDATE slot while
//      full; 5th accepted the cycle after first pop; FIFO drains in arrival order.
//   6. rst_n low during cycle after lookup accept with 2 queued updates -> rsp_valid=0, upd_ready=1,
//      pr_request=pr_result=0 immediately; no stale response after rst_n rises.

Source files
------------

// File: rtl/bp_sched_pkg.sv
// bp_sched_pkg
//   Shared types and default parameter values for the branch-predictor port
//   scheduler and its update FIFO.
//   slot_e : what the single predictor port is used for in a given cycle.
package bp_sched_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_LOOKUP = 2'd1,
        SLOT_UPDATE = 2'd2
    } slot_e;

    localparam int DEF_N_REQ     = 2;
    localparam int DEF_UPD_DEPTH = 4;
    localparam int DEF_MAX_WAIT  = 8;

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo
//   DEPTH x 1-bit synchronous FIFO holding resolved-branch outcomes until the
//   predictor port has a free update slot.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, push_data   write request and outcome bit (ignored while full)
//     pop               read request (ignored while empty)
//     full, empty       registered occupancy flags
//     head              oldest stored outcome
//   A push into an empty FIFO becomes visible at the head only on the next
//   cycle; there is no bypass path from push_data to head.
module bp_upd_fifo
    import bp_sched_pkg::*;
#(
    parameter int DEPTH = DEF_UPD_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bp_port_scheduler.sv
// bp_port_scheduler
//   Shares one single-ported 2-bit branch predictor between N_REQ lookup
//   requesters and a stream of resolved-branch updates. Each cycle the port
//   carries one lookup, one update, or nothing.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     lk_req / lk_gnt       per-requester lookup request and one-hot grant
//     rsp_valid/id/taken    prediction response, tagged with requester index
//     upd_valid/taken/ready resolved-branch update handshake
//     pr_request/result/taken  registered commands to the predictor
//     pr_prediction         predictor output, valid the cycle after pr_request
//
//   Handshakes: a lookup transfers on a rising edge where lk_req[i] and
//   lk_gnt[i] are both high; requesters hold lk_req until granted. An update
//   transfers on a rising edge where upd_valid and upd_ready are both high;
//   while upd_ready is low the source holds upd_taken and nothing changes.
//   upd_ready depends only on registered occupancy, never on upd_valid.
module bp_port_scheduler
    import bp_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int UPD_DEPTH = DEF_UPD_DEPTH,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         lk_req,
    output logic [N_REQ-1:0]         lk_gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_taken,
    input  logic                     upd_valid,
    input  logic                     upd_taken,
    output logic                     upd_ready,
    output logic                     pr_request,
    output logic                     pr_result,
    output logic                     pr_taken,
    input  logic                     pr_prediction
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    slot_e           slot;
    logic            fifo_full, fifo_empty, fifo_head;
    logic            fifo_push, fifo_pop;
    logic            force_upd;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    int              idx;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             pr_request_q, pr_request_d;
    logic             pr_result_q, pr_result_d;
    logic             pr_taken_q, pr_taken_d;
    logic [ID_W-1:0]  issue_id_q, issue_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (upd_taken),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign upd_ready = !fifo_full;
    assign fifo_push = upd_valid && upd_ready;

    // Round-robin search starting at the pointer.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr_q) + off) % N_REQ;
            if (!win_found && lk_req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Slot choice: a full FIFO or a starved head pre-empts lookups; otherwise
    // lookups win and updates fill idle cycles.
    always_comb begin
        force_upd = fifo_full || (!fifo_empty && (age_q == AGE_MAX));
        if (force_upd) begin
            slot = SLOT_UPDATE;
        end else if (win_found) begin
            slot = SLOT_LOOKUP;
        end else if (!fifo_empty) begin
            slot = SLOT_UPDATE;
        end else begin
            slot = SLOT_IDLE;
        end
    end

    always_comb begin
        lk_gnt = '0;
        if (slot == SLOT_LOOKUP) begin
            lk_gnt[win_id] = 1'b1;
        end
    end

    assign fifo_pop = (slot == SLOT_UPDATE);

    always_comb begin
        ptr_d        = ptr_q;
        age_d        = age_q;
        issue_id_d   = issue_id_q;
        rsp_id_d     = rsp_id_q;
        pr_request_d = (slot == SLOT_LOOKUP);
        pr_result_d  = (slot == SLOT_UPDATE);
        pr_taken_d   = (slot == SLOT_UPDATE) && fifo_head;
        rsp_valid_d  = pr_request_q;

        if (slot == SLOT_LOOKUP) begin
            ptr_d      = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
            issue_id_d = win_id;
        end

        // Age measures how long the current head has been passed over.
        if (fifo_empty || fifo_pop) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end

        // The id follows the lookup one stage behind pr_request so it lines
        // up with the prediction the predictor returns.
        if (pr_request_q) begin
            rsp_id_d = issue_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            age_q        <= '0;
            pr_request_q <= 1'b0;
            pr_result_q  <= 1'b0;
            pr_taken_q   <= 1'b0;
            issue_id_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            age_q        <= age_d;
            pr_request_q <= pr_request_d;
            pr_result_q  <= pr_result_d;
            pr_taken_q   <= pr_taken_d;
            issue_id_q   <= issue_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign pr_request = pr_request_q;
    assign pr_result  = pr_result_q;
    assign pr_taken   = pr_taken_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    // The predictor registers its own output, so it is already aligned with
    // rsp_valid.
    assign rsp_taken  = pr_prediction;

endmodule

// File: tb/tb_bp_port_scheduler.sv
module tb_bp_port_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] lk_req;
    logic [1:0] lk_gnt;
    logic       rsp_valid;
    logic [0:0] rsp_id;
    logic       rsp_taken;
    logic       upd_valid;
    logic       upd_taken;
    logic       upd_ready;
    logic       pr_request;
    logic       pr_result;
    logic       pr_taken;
    logic       pr_prediction;

    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];

    bp_port_scheduler #(
        .N_REQ     (2),
        .UPD_DEPTH (4),
        .MAX_WAIT  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_req        (lk_req),
        .lk_gnt        (lk_gnt),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_taken     (rsp_taken),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .upd_ready     (upd_ready),
        .pr_request    (pr_request),
        .pr_result     (pr_result),
        .pr_taken      (pr_taken),
        .pr_prediction (pr_prediction)
    );

    // Attached predictor: one 2-bit saturating counter, powers up at 3,
    // not affected by the scheduler reset.
    logic [1:0] ctr = 2'd3;
    logic       pred = 1'b0;
    always @(posedge clk) begin
        if (pr_result) begin
            if (pr_taken && ctr != 2'd3) ctr <= ctr + 2'd1;
            else if (!pr_taken && ctr != 2'd0) ctr <= ctr - 2'd1;
        end
        if (pr_request) pred <= ctr[1];
    end
    assign pr_prediction = pred;

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; lk_req = 2'b00; upd_valid = 1'b0; upd_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (pr_request !== 1'b0) begin errors++; $display("FAIL rst_pr_request: got %b expected 0", pr_request); end
        checks++; if (pr_result !== 1'b0) begin errors++; $display("FAIL rst_pr_result: got %b expected 0", pr_result); end
        checks++; if (pr_taken !== 1'b0) begin errors++; $display("FAIL rst_pr_taken: got %b expected 0", pr_taken); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id: got %b expected 0", rsp_id); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_upd_ready: got %b expected 1", upd_ready); end
        checks++; if (lk_gnt !== 2'b00) begin errors++; $display("FAIL rst_lk_gnt: got %b expected 00", lk_gnt); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_lookup();
        lk_req = 2'b01;
        @(negedge clk);
        checks++; if (lk_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", lk_gnt); end
        next_cycle();
        lk_req = 2'b00;
        @(negedge clk);
        checks++; if (pr_request !== 1'b1) begin errors++; $display("FAIL single_pr_request: got %b expected 1", pr_request); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early: got %b expected 0", rsp_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %b expected 0", rsp_id); end
        checks++; if (rsp_taken !== 1'b1) begin errors++; $display("FAIL single_rsp_taken: got %b expected 1", rsp_taken); end
        checks++; if (pr_request !== 1'b0) begin errors++; $display("FAIL single_pr_request_drop: got %b expected 0", pr_request); end
        next_cycle();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_one_cycle: got %b expected 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_updates_then_lookup();
        upd_valid = 1'b1; upd_taken = 1'b0;
        @(negedge clk);
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL upd_ready_empty: got %b expected 1", upd_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (pr_result !== 1'b0) begin errors++; $display("FAIL upd_no_bypass: got %b expected 0", pr_result); end
        next_cycle();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++; if ({pr_result, pr_taken} !== 2'b10) begin errors++; $display("FAIL upd_first: got %b expected 10", {pr_result, pr_taken}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({pr_result, pr_taken} !== 2'b10) begin errors++; $display("FAIL upd_second: got %b expected 10", {pr_result, pr_taken}); end
        next_cycle();
        @(negedge clk);
        checks++; if (pr_result !== 1'b0) begin errors++; $display("FAIL upd_drained: got %b expected 0", pr_result); end
        // counter now 1: lookup from requester 1 predicts not-taken
        lk_req = 2'b10;
        next_cycle();
        lk_req = 2'b00;
        next_cycle();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_taken} !== 3'b110) begin errors++; $display("FAIL upd_lookup_rsp: got %b expected 110", {rsp_valid, rsp_id, rsp_taken}); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        lk_req = 2'b11;
        for (int k = 0; k < 9; k++) begin
            if (k == 6) lk_req = 2'b00;
            @(negedge clk);
            if (k < 6) begin
                exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (lk_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, lk_gnt, exp_gnt); end
            end
            if (k >= 2 && k < 8) begin
                checks++; if ({rsp_valid, rsp_id, rsp_taken} !== {1'b1, 1'((k - 2) % 2), 1'b0}) begin
                    errors++; $display("FAIL rr_rsp[%0d]: got %b expected %b", k, {rsp_valid, rsp_id, rsp_taken}, {1'b1, 1'((k - 2) % 2), 1'b0});
                end
            end
            if (k == 8) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_end: got %b expected 0", rsp_valid); end
            end
            next_cycle();
        end
    endtask

    task automatic test_forced_update();
        logic [1:0] exp_gnt;
        lk_req = 2'b11; upd_valid = 1'b1; upd_taken = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 1) upd_valid = 1'b0;
            if (k == 11) lk_req = 2'b00;
            @(negedge clk);
            if (k <= 8) begin
                exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (lk_gnt !== exp_gnt) begin errors++; $display("FAIL age_gnt[%0d]: got %b expected %b", k, lk_gnt, exp_gnt); end
            end
            if (k == 9) begin
                checks++; if ({lk_gnt, pr_result} !== 3'b000) begin errors++; $display("FAIL age_forced_slot: got %b expected 000", {lk_gnt, pr_result}); end
            end
            if (k == 10) begin
                checks++; if (lk_gnt !== 2'b10) begin errors++; $display("FAIL age_resume_gnt: got %b expected 10", lk_gnt); end
                checks++; if ({pr_result, pr_taken} !== 2'b11) begin errors++; $display("FAIL age_update: got %b expected 11", {pr_result, pr_taken}); end
                checks++; if ({rsp_valid, rsp_id, rsp_taken} !== 3'b100) begin errors++; $display("FAIL age_old_ctr_rsp: got %b expected 100", {rsp_valid, rsp_id, rsp_taken}); end
            end
            if (k == 12) begin
                checks++; if ({rsp_valid, rsp_id, rsp_taken} !== 3'b111) begin errors++; $display("FAIL age_new_ctr_rsp: got %b expected 111", {rsp_valid, rsp_id, rsp_taken}); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] data;
        logic [0:0] exp_bit;
        int pushes;
        int pops;
        int fifth_k;
        int k;
        data = 5'b01101;  // arrival order: bit0 first
        pushes = 0; pops = 0; fifth_k = -1; k = 0;
        exp_q.delete();
        lk_req = 2'b11;
        while (pops < 5 && k < 100) begin
            upd_valid = (pushes < 5);
            upd_taken = (pushes < 5) ? data[pushes] : 1'b0;
            @(negedge clk);
            checks++; if (pr_request && pr_result) begin errors++; $display("FAIL b2b_exclusive[%0d]: got 11 expected not both", k); end
            if (pr_result) begin
                exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                checks++; if (pr_taken !== exp_bit) begin errors++; $display("FAIL b2b_order[%0d]: got %b expected %b", pops, pr_taken, exp_bit); end
                pops++;
            end
            if (k == 3) begin
                checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_k3: got %b expected 1", upd_ready); end
            end
            if (k == 4) begin
                checks++; if ({upd_ready, lk_gnt} !== 3'b000) begin errors++; $display("FAIL b2b_full_slot: got %b expected 000", {upd_ready, lk_gnt}); end
            end
            if (k == 5) begin
                checks++; if ({upd_ready, pr_result} !== 2'b11) begin errors++; $display("FAIL b2b_after_pop: got %b expected 11", {upd_ready, pr_result}); end
            end
            if (upd_valid && upd_ready) begin
                exp_q.push_back(upd_taken);
                pushes++;
                if (pushes == 5) fifth_k = k;
            end
            next_cycle();
            k++;
        end
        lk_req = 2'b00; upd_valid = 1'b0;
        checks++; if (pops !== 5) begin errors++; $display("FAIL b2b_pop_count: got %0d expected 5", pops); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
        checks++; if (fifth_k !== 5) begin errors++; $display("FAIL b2b_fifth_accept_cycle: got %0d expected 5", fifth_k); end
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_midop();
        lk_req = 2'b01; upd_valid = 1'b1; upd_taken = 1'b1;
        next_cycle();
        next_cycle();
        lk_req = 2'b00; upd_valid = 1'b0;
        checks++; if (pr_request !== 1'b1) begin errors++; $display("FAIL rmid_setup_pr_request: got %b expected 1", pr_request); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, upd_ready, pr_request, pr_result} !== 4'b0100) begin
            errors++; $display("FAIL rmid_async: got %b expected 0100", {rsp_valid, upd_ready, pr_request, pr_result});
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if ({rsp_valid, pr_request, pr_result} !== 3'b000) begin
                errors++; $display("FAIL rmid_quiet[%0d]: got %b expected 000", k, {rsp_valid, pr_request, pr_result});
            end
            next_cycle();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_lookup();
        test_updates_then_lookup();
        test_round_robin();
        test_forced_update();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
